// File: rtl/conv_cfg_writer.sv
// Host-side master for the accelerator configuration register: validates a
// convolution job, writes the packed word, then counts valid pulses to done.
module conv_cfg_writer #(
  parameter int DATA_W    = 128,
  parameter int WR_CYCLES = 1,
  parameter int TIMEOUT   = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [3:0]        i_in_size,
  input  logic [2:0]        i_k_size,
  input  logic [2:0]        i_stride,
  output logic              o_cfg_en,
  output logic              o_cfg_r_w,
  output logic [DATA_W-1:0] o_cfg_word,
  input  logic              i_valid_in,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_err,
  output logic [9:0]        o_out_count
);

  localparam int              TMR_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
  localparam logic [3:0]       WR_MAX  = 4'(WR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_WRITE = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  logic [3:0]          r_n;
  logic [2:0]          r_k;
  logic [2:0]          r_s;
  logic [7:0]          r_exp;
  logic [3:0]          r_wr_cnt;
  logic [TMR_W-1:0]    r_timer;
  logic                r_cfg_en;
  logic                r_cfg_r_w;
  logic [DATA_W-1:0]   r_cfg_word;
  logic                r_busy;
  logic                r_done;
  logic [1:0]          r_err;
  logic [9:0]          r_out_count;

  state_t              w_next;
  logic [3:0]          w_n;
  logic [2:0]          w_k;
  logic [2:0]          w_s;
  logic [7:0]          w_exp_nxt;
  logic [3:0]          w_wr_cnt;
  logic [TMR_W-1:0]    w_timer;
  logic                w_cfg_en;
  logic                w_cfg_r_w;
  logic [DATA_W-1:0]   w_cfg_word;
  logic                w_busy;
  logic                w_done;
  logic [1:0]          w_err;
  logic [9:0]          w_out_count;

  logic                w_illegal;
  logic [3:0]          w_diff;
  logic [3:0]          w_divisor;
  logic [3:0]          w_dim;
  logic [7:0]          w_dim8;
  logic [7:0]          w_exp;
  logic [9:0]          w_count_inc;
  logic [DATA_W-1:0]   w_packed;

  // Job arithmetic on the captured configuration; the divisor is forced
  // nonzero so an illegal S=0 job never divides by zero.
  always_comb begin
    w_illegal   = (r_k == 3'd0) || (r_s == 3'd0) || ({1'b0, r_k} > r_n);
    w_diff      = r_n - {1'b0, r_k};
    w_divisor   = (r_s == 3'd0) ? 4'd1 : {1'b0, r_s};
    w_dim       = w_diff / w_divisor;
    w_dim8      = {4'd0, w_dim} + 8'd1;
    w_exp       = w_dim8 * w_dim8;
    w_count_inc = r_out_count + 10'd1;
    w_packed    = {{(DATA_W-12){1'b0}}, r_s, 1'b0, r_k, 1'b0, r_n};
  end

  // Next-state and next-register logic; outputs are decoded from the next state
  // so every output leaves a flop.
  always_comb begin
    w_next      = r_state;
    w_n         = r_n;
    w_k         = r_k;
    w_s         = r_s;
    w_exp_nxt   = r_exp;
    w_wr_cnt    = r_wr_cnt;
    w_timer     = r_timer;
    w_cfg_word  = r_cfg_word;
    w_err       = r_err;
    w_out_count = r_out_count;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_n         = i_in_size;
          w_k         = i_k_size;
          w_s         = i_stride;
          w_out_count = 10'd0;
          w_err       = 2'd0;
          w_next      = S_CALC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (w_illegal) begin
          w_err  = 2'd1;
          w_next = S_DONE;
        end else begin
          w_exp_nxt  = w_exp;
          w_cfg_word = w_packed;
          w_wr_cnt   = 4'd0;
          w_next     = S_WRITE;
        end
      end
      S_WRITE: begin
        w_timer = '0;
        if (r_wr_cnt == WR_MAX) begin
          w_next = S_RUN;
        end else begin
          w_wr_cnt = r_wr_cnt + 4'd1;
        end
      end
      S_RUN: begin
        // A pulse on the expiry cycle still counts and restarts the timer.
        if (i_valid_in) begin
          w_out_count = w_count_inc;
          w_timer     = '0;
          if (w_count_inc == {2'b00, r_exp}) begin
            w_next = S_DONE;
          end else begin
            w_next = S_RUN;
          end
        end else if (r_timer == TMR_MAX) begin
          w_err  = 2'd2;
          w_next = S_DONE;
        end else begin
          w_timer = r_timer + TMR_ONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    w_cfg_en  = (w_next == S_WRITE) || (w_next == S_RUN);
    w_cfg_r_w = (w_next == S_WRITE);
    w_busy    = (w_next != S_IDLE);
    w_done    = (w_next == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_n         <= 4'd0;
      r_k         <= 3'd0;
      r_s         <= 3'd0;
      r_exp       <= 8'd0;
      r_wr_cnt    <= 4'd0;
      r_timer     <= '0;
      r_cfg_en    <= 1'b0;
      r_cfg_r_w   <= 1'b0;
      r_cfg_word  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 2'd0;
      r_out_count <= 10'd0;
    end else begin
      r_state     <= w_next;
      r_n         <= w_n;
      r_k         <= w_k;
      r_s         <= w_s;
      r_exp       <= w_exp_nxt;
      r_wr_cnt    <= w_wr_cnt;
      r_timer     <= w_timer;
      r_cfg_en    <= w_cfg_en;
      r_cfg_r_w   <= w_cfg_r_w;
      r_cfg_word  <= w_cfg_word;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_err       <= w_err;
      r_out_count <= w_out_count;
    end
  end

  assign o_cfg_en    = r_cfg_en;
  assign o_cfg_r_w   = r_cfg_r_w;
  assign o_cfg_word  = r_cfg_word;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_out_count = r_out_count;

endmodule

// File: doc/conv_cfg_writer.md
Name: conv_cfg_writer

Overview:
Host-side master for the accelerator's configuration register. It takes a convolution job (input size, kernel size, stride), validates it, packs it into the 128-bit configuration word, and issues the write (en / r_w strobe) to the register. It then tracks the register's `valid` output pulses until the expected number of output pixels has been produced, and reports done, error or timeout. It sits between the host/test sequencer and the configuration register, driving that register's write port and consuming its `valid` output.

Parameters:
DATA_W, 128, width of the configuration word.
WR_CYCLES, 1, number of cycles `cfg_r_w` is held high per write (legal range 1..15).
TIMEOUT, 4096, cycles allowed in RUN between consecutive `valid_in` pulses before error.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  reset; synchronous, active-high.
start  in  1  job request; sampled only in IDLE.
in_size  in  4  input feature-map side N (NxN).
k_size  in  3  kernel side K (KxK).
stride  in  3  stride S.
cfg_en  out  1  enable to the configuration register.
cfg_r_w  out  1  write strobe to the configuration register.
cfg_word  out  DATA_W  packed configuration word.
valid_in  in  1  `valid` pulse from the configuration register / datapath, one per output pixel.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at job end (success or error).
err  out  2  0 = ok, 1 = illegal config, 2 = timeout.
out_count  out  10  number of `valid_in` pulses counted in the current job.

Behaviour:
- Reset (`rst` = 1 at an edge): state goes to IDLE. All outputs are 0: `cfg_en`, `cfg_r_w`, `cfg_word`, `busy`, `done`, `err`, `out_count`. Internal counters are cleared. Reset mid-job abandons the job with no done pulse.
- Word packing:
  - `cfg_word[3:0]` = in_size; `[4]` = 0; `[7:5]` = k_size; `[8]` = 0; `[11:9]` = stride; `[DATA_W-1:12]` = 0.
  - Example: N=5, K=3, S=1 gives 0x265; S=2 gives 0x465; S=3 gives 0x665.
- Inputs `in_size`, `k_size` and `stride` are captured on the start edge and held internally; later input changes have no effect on the job.
- Illegal configuration: K==0, S==0, or K>N.
- Output dimension: D = floor((N-K)/S) + 1. Expected count E = D*D, 8-bit unsigned, maximum 225.
- States:
  - IDLE: `busy`=0. If `start`=1, capture inputs, clear `out_count`, clear `err`, and go to CALC.
  - CALC (exactly 1 cycle):
    - If illegal: `err`<=1 and go to DONE. No write is issued; `cfg_en` and `cfg_r_w` stay 0.
    - Otherwise: register E, drive `cfg_word`, and go to WRITE.
  - WRITE: `cfg_en`=1, `cfg_r_w`=1 for exactly WR_CYCLES cycles, then go to RUN. `valid_in` is ignored in this state.
  - RUN: `cfg_en`=1, `cfg_r_w`=0.
    - Each `valid_in`=1 cycle increments `out_count` and clears the idle-timer.
    - When the increment makes `out_count`==E, go to DONE.
    - If the idle-timer reaches TIMEOUT-1 with no `valid_in`, set `err`<=2 and go to DONE.
    - If `valid_in` and timer expiry occur in the same cycle, `valid_in` wins: count it, restart the timer.
  - DONE (1 cycle): `done`=1, `cfg_en`=0, then go to IDLE.
- Held values after DONE:
  - `cfg_word` holds its last value until the next CALC.
  - `err` and `out_count` hold until the next accepted `start`.
- `start` outside IDLE is ignored; no queueing.
- `start` is not sampled in the DONE cycle.
- `valid_in` outside RUN is ignored; extra pulses after E are never counted.
- Latency, start edge to first `cfg_r_w`=1 cycle: 2 cycles (IDLE then CALC).
- Latency, final counted `valid_in` to `done`: 1 cycle.

Test Plan:
1. Legal job, no stride: reset, then start with N=5, K=3, S=1.
   - `cfg_word`=0x265; `cfg_r_w` high 1 cycle, 2 cycles after start.
   - After 9 `valid_in` pulses: `done` pulses 1 cycle later, `err`=0, `out_count`=9.
2. Same job with S=2 and then S=3.
   - S=2: word 0x465, E=4.
   - S=3: word 0x665, E=1.
   - Each ends with `done` and `err`=0.
3. Illegal configurations: N=2, K=3, S=1, then N=5, K=3, S=0.
   - No `cfg_r_w`/`cfg_en` activity in either case.
   - `done` 2 cycles after start, `err`=1.
4. Timeout, with TIMEOUT=16: legal job, then 2 `valid_in` pulses, then silence.
   - `err`=2, `out_count`=2, `done` after 16 idle cycles.
   - Repeat with a `valid_in` on the expiry cycle: no timeout occurs.
5. Protocol robustness:
   - `start` pulses while busy and `valid_in` during WRITE are ignored.
   - WR_CYCLES=3 gives a 3-cycle `cfg_r_w`.
   - 5 extra `valid_in` pulses after DONE leave `out_count` unchanged.
6. Reset mid-RUN after 4 pulses (N=5, K=3, S=1):
   - All outputs are 0 the next cycle, with no `done` pulse.
   - A new start runs normally to 9.
